uf7_add_seq: RTL and testbench
==============================

# uf7_add_seq

Multi-cycle sequencer for 7-bit unsigned float addition. Format: 3-bit exponent in bits 6:4 and 4-bit mantissa in bits 3:0, with an implicit leading 1. The block accepts operand pairs with any exponents over a valid/ready handshake. It aligns the smaller operand one bit per cycle, adds, normalizes, rounds half-up and flags exponent overflow. It replaces the single-cycle equal-exponent adder wherever operands can differ in exponent.

## Interface
Parameters:
- EXP_W, default 3: exponent field width.
- MAN_W, default 4: mantissa field width, hidden bit excluded.

Ports:
- clk, input, 1: single clock; every register samples on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- a, input, EXP_W+MAN_W: operand A; sampled only on accept.
- b, input, EXP_W+MAN_W: operand B; sampled only on accept.
- in_valid, input, 1: operand pair available.
- in_ready, output, 1: block can accept; high only in IDLE.
- c, output, EXP_W+MAN_W: registered result.
- o, output, 1: overflow flag; valid with c.
- out_valid, output, 1: result valid; high only in DONE.
- out_ready, input, 1: consumer takes the result.

## Operation
- Accept occurs on an edge with in_valid and in_ready both high.
- On accept, register the operands so that E holds the larger exponent.
  - On a tie, A is the larger operand.
  - MA = {1, man_big, 0} and MB = {1, man_small, 0}: MAN_W+2 bits, with a guard LSB.
  - D = min(e_big − e_small, MAN_W+2).
- FSM states: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE: on accept, go to ALIGN if D>0, else to ADD.
- ALIGN: each cycle, MB >>= 1 and D−−. Bits shifted below the guard are discarded (no sticky bit). Leave for ADD when D reaches 0.
- ADD: S = MA + MB, MAN_W+3 bits.
- NORM:
  - If S MSB is 1: mant = S[MAN_W+1:2], guard = S[1], exp = E+1.
  - Otherwise: mant = S[MAN_W:1], guard = S[0], exp = E.
  - exp is EXP_W+1 bits wide.
- ROUND:
  - If guard=1, mant += 1.
  - If that carries out, mant = 0 and exp += 1.
  - If exp > 2^EXP_W−1: o=1 and c saturates to all ones.
  - Otherwise: o=0 and c = {exp, mant}.
  - c and o are registered in this state.
- DONE: hold c, o and out_valid=1 until out_ready; then go to IDLE.
- in_ready = (state==IDLE). There is no accept in the same cycle as a DONE handshake. Throughput is one operation per latency+1 cycles minimum.
- a and b may change freely after accept; the result is unaffected.
- Reset mid-operation: the operation is abandoned and no result is emitted.

## Timing
- Reset, after the first edge with rst_n=0: state=IDLE, in_ready=1, out_valid=0, c=0, o=0. Internal operand registers are also cleared.
- Latency: out_valid rises 3 + min(Δe, MAN_W+2) edges after the accept edge.
  - Equal exponents: 3.
  - Worst case: 9.
- out_valid stays high and c/o stay stable while out_ready=0.
- out_valid falls on the edge where out_valid && out_ready.
- out_ready while not DONE is ignored.
- in_valid while busy is ignored; no pair is captured.

## Structure
- Shared package uf7_pkg holds:
  - EXP_W and MAN_W defaults.
  - The state enum.
  - UF7_SAT = all-ones result constant.
- One sub-module, uf7_norm_round: combinational NORM+ROUND logic. Inputs are S and E; outputs are exp, mant and overflow. The top level registers its outputs in ROUND.

## Test plan
- a=1001000, b=1001000 → c=1011000, o=0, out_valid 3 edges after accept.
- a=1000001, b=1000000 → c=1010001 (guard rounds up), o=0, latency 3.
- a=1011000, b=0111000 → c=1011110, latency 5. Repeating with a and b swapped gives an identical result and latency.
- a=1011111, b=0001000 (Δe=5) → round carry gives c=1100000, o=0, latency 8.
- Overflow and saturation:
  - a=b=1111000 → o=1, c=1111111.
  - a=1111000, b=0001000 (Δe=7, capped at 6) → c=1111000, o=0, latency 9.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE: c, o and out_valid stay stable, and in_ready=0 with in_valid high captures nothing.
  - Pulse rst_n=0 during ALIGN: next edge shows IDLE, in_ready=1, out_valid=0, and no result is emitted.

Source files
------------

// File: rtl/uf7_pkg.sv
// Shared definitions for the 7-bit unsigned float sequential adder:
// default field widths, FSM state encoding and the saturated result.
package uf7_pkg;

  localparam int UF7_EXP_W = 3;
  localparam int UF7_MAN_W = 4;

  localparam logic [UF7_EXP_W+UF7_MAN_W-1:0] UF7_SAT = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/uf7_norm_round.sv
// Combinational normalize + round-half-up stage. Takes the raw mantissa sum
// and the larger exponent, produces the final exponent, mantissa and overflow.
module uf7_norm_round
  import uf7_pkg::*;
#(
  parameter int EXP_W = UF7_EXP_W,
  parameter int MAN_W = UF7_MAN_W
) (
  input  logic [MAN_W+2:0] s,
  input  logic [EXP_W-1:0] e,
  output logic [EXP_W:0]   res_exp,
  output logic [MAN_W-1:0] res_mant,
  output logic             overflow
);

  logic [MAN_W-1:0] norm_mant;
  logic             guard;
  logic [EXP_W:0]   norm_exp;
  logic [MAN_W:0]   rounded;

  always_comb begin
    norm_mant = '0;
    guard     = 1'b0;
    norm_exp  = '0;
    rounded   = '0;
    res_exp   = '0;
    res_mant  = '0;

    // A carry into the sum MSB means the value doubled: shift right once.
    if (s[MAN_W+2]) begin
      norm_mant = s[MAN_W+1:2];
      guard     = s[1];
      norm_exp  = {1'b0, e} + (EXP_W+1)'(1);
    end else begin
      norm_mant = s[MAN_W:1];
      guard     = s[0];
      norm_exp  = {1'b0, e};
    end

    rounded = {1'b0, norm_mant} + (MAN_W+1)'(guard);
    if (rounded[MAN_W]) begin
      res_mant = '0;
      res_exp  = norm_exp + (EXP_W+1)'(1);
    end else begin
      res_mant = rounded[MAN_W-1:0];
      res_exp  = norm_exp;
    end

    overflow = res_exp[EXP_W];
  end

endmodule

// File: rtl/uf7_add_seq.sv
// Multi-cycle unsigned float adder: accepts any exponent pair, aligns the
// smaller operand one bit per cycle, then adds, normalizes and rounds.
module uf7_add_seq
  import uf7_pkg::*;
#(
  parameter int EXP_W = UF7_EXP_W,
  parameter int MAN_W = UF7_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [EXP_W+MAN_W-1:0] a,
  input  logic [EXP_W+MAN_W-1:0] b,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [EXP_W+MAN_W-1:0] c,
  output logic                   o,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int D_MAX = MAN_W + 2;
  localparam int D_W   = $clog2(MAN_W + 3);
  localparam logic [EXP_W+MAN_W-1:0] SAT = '1;

  state_t state_reg, state_next;

  logic [EXP_W-1:0]       e_reg;
  logic [MAN_W+1:0]       ma_reg, mb_reg;
  logic [D_W-1:0]         d_reg;
  logic [MAN_W+2:0]       s_reg;
  logic [EXP_W+MAN_W-1:0] c_reg;
  logic                   o_reg;

  logic [EXP_W-1:0] exp_a, exp_b, e_big, e_small, e_diff;
  logic [MAN_W-1:0] man_big, man_small;
  logic [D_W-1:0]   d_init;

  logic [EXP_W:0]   res_exp;
  logic [MAN_W-1:0] res_mant;
  logic             overflow;

  // Operand ordering: on an exponent tie A is treated as the larger one.
  always_comb begin
    exp_a = a[EXP_W+MAN_W-1:MAN_W];
    exp_b = b[EXP_W+MAN_W-1:MAN_W];
    if (exp_a >= exp_b) begin
      e_big     = exp_a;
      e_small   = exp_b;
      man_big   = a[MAN_W-1:0];
      man_small = b[MAN_W-1:0];
    end else begin
      e_big     = exp_b;
      e_small   = exp_a;
      man_big   = b[MAN_W-1:0];
      man_small = a[MAN_W-1:0];
    end
    e_diff = e_big - e_small;
    if (32'(e_diff) > 32'(D_MAX)) d_init = D_W'(D_MAX);
    else                          d_init = D_W'(e_diff);
  end

  uf7_norm_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_norm_round (
    .s       (s_reg),
    .e       (e_reg),
    .res_exp (res_exp),
    .res_mant(res_mant),
    .overflow(overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (in_valid) state_next = (d_init != '0) ? ST_ALIGN : ST_ADD;
      ST_ALIGN: if (d_reg == D_W'(1)) state_next = ST_ADD;
      ST_ADD:   state_next = ST_NORM;
      ST_NORM:  state_next = ST_ROUND;
      ST_ROUND: state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_reg  <= '0;
      ma_reg <= '0;
      mb_reg <= '0;
      d_reg  <= '0;
      s_reg  <= '0;
      c_reg  <= '0;
      o_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            e_reg  <= e_big;
            ma_reg <= {1'b1, man_big, 1'b0};
            mb_reg <= {1'b1, man_small, 1'b0};
            d_reg  <= d_init;
          end
        end
        ST_ALIGN: begin
          // Bits falling off below the guard are simply dropped.
          mb_reg <= mb_reg >> 1;
          d_reg  <= d_reg - D_W'(1);
        end
        ST_ADD:   s_reg <= {1'b0, ma_reg} + {1'b0, mb_reg};
        ST_ROUND: begin
          c_reg <= overflow ? SAT : {res_exp[EXP_W-1:0], res_mant};
          o_reg <= overflow;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign c         = c_reg;
  assign o         = o_reg;

endmodule

// File: tb/tb_uf7_add_seq.sv
// Directed-vector bench for uf7_add_seq: results, latency, handshake and reset.
module tb_uf7_add_seq;
  import uf7_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] a, b;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] c;
  logic       o;
  logic       out_valid;
  logic       out_ready;

  int errors = 0;
  int checks = 0;

  uf7_add_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .c        (c),
    .o        (o),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Drives one accept, scrambles the inputs afterwards, and waits (bounded)
  // for out_valid. lat = edges from accept to out_valid, or 99 on timeout.
  task automatic run_op(input logic [6:0] va, input logic [6:0] vb,
                        output logic [6:0] rc, output logic ro, output int lat);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    a = va;
    b = vb;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~va;
    b = 7'h2a;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = 99;
    rc = c;
    ro = o;
    $display("op a=%b b=%b -> c=%b o=%b latency=%0d", va, vb, rc, ro, lat);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 7'b0 || o !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b c=%b o=%b, want 1 0 0000000 0",
               in_ready, out_valid, c, o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: in_ready=%b out_valid=%b c=%b o=%b", in_ready, out_valid, c, o);
  endtask

  // Ordinary operations: result, overflow flag and latency vs. hand values.
  task automatic test_vectors();
    logic [6:0] va [7];
    logic [6:0] vb [7];
    logic [6:0] ec [7];
    logic       eo [7];
    int         el [7];
    logic [6:0] rc;
    logic       ro;
    int         lat;
    va = '{7'b1001000, 7'b1000001, 7'b1011000, 7'b0111000, 7'b1011111, 7'b1111000, 7'b1111000};
    vb = '{7'b1001000, 7'b1000000, 7'b0111000, 7'b1011000, 7'b0001000, 7'b1111000, 7'b0001000};
    ec = '{7'b1011000, 7'b1010001, 7'b1011110, 7'b1011110, 7'b1100000, UF7_SAT,    7'b1111000};
    eo = '{1'b0,       1'b0,       1'b0,       1'b0,       1'b0,       1'b1,       1'b0};
    el = '{3,          3,          5,          5,          8,          3,          9};
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], rc, ro, lat);
      checks++;
      if (rc !== ec[i] || ro !== eo[i]) begin
        errors++;
        $display("FAIL vec%0d result: c=%b o=%b, want c=%b o=%b", i, rc, ro, ec[i], eo[i]);
      end
      checks++;
      if (lat !== el[i]) begin
        errors++;
        $display("FAIL vec%0d latency: got %0d, want %0d", i, lat, el[i]);
      end
      release_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d release: out_valid=%b in_ready=%b, want 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  // DONE with out_ready low: outputs hold, and in_valid is not captured.
  task automatic test_hold();
    logic [6:0] rc;
    logic       ro;
    int         lat;
    run_op(7'b1011000, 7'b0111000, rc, ro, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 7'b1111000;
      b = 7'b1111000;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || c !== 7'b1011110 || o !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: out_valid=%b in_ready=%b c=%b o=%b, want 1 0 1011110 0",
                 i, out_valid, in_ready, c, o);
      end
      $display("hold cycle %0d: out_valid=%b in_ready=%b c=%b", i, out_valid, in_ready, c);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_capture: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  // Reset pulse while aligning abandons the operation.
  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    a = 7'b1111000;
    b = 7'b0001000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: in_ready=%b, want 0", in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 7'b0 || o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b c=%b o=%b, want 1 0 0000000 0",
               in_ready, out_valid, c, o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_no_result: out_valid high %0d cycles, want 0", seen);
    end
    $display("reset mid-align: out_valid cycles after reset=%0d", seen);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
